// File: rtl/sin_cordic_q230_gen_if.sv
// Request/result bundle for sin_cordic_q230_gen.
// The bench (master) drives ftw/sample_en/out_ready; the generator (slave)
// returns the Q2.30 sample and status. cos_out exists only when COS_OUT_EN is defined.
interface sin_cordic_q230_gen_if;
    logic        [31:0] ftw;
    logic               sample_en;
    logic               out_ready;
    logic               out_valid;
    logic signed [31:0] sin_out;
    logic               busy;
    logic               overrun;
`ifdef COS_OUT_EN
    logic signed [31:0] cos_out;
`endif

    modport master (
        output ftw, sample_en, out_ready,
        input  out_valid, sin_out, busy, overrun
`ifdef COS_OUT_EN
        , input cos_out
`endif
    );

    modport slave (
        input  ftw, sample_en, out_ready,
        output out_valid, sin_out, busy, overrun
`ifdef COS_OUT_EN
        , output cos_out
`endif
    );
endinterface

// File: rtl/sin_cordic_q230_gen.sv
// Phase accumulator + iterative CORDIC sine source, signed Q2.30 output.
// One sample per request: fold phase to +/-90 deg, ITER micro-steps at one per
// clock, then register the result and hold it until the consumer takes it.
// Optional feature macro: COS_OUT_EN (adds the registered cos_out result).
module sin_cordic_q230_gen #(
    parameter int          ITER       = 24,     // legal range 8..30
    parameter logic [31:0] INIT_PHASE = 32'h0
) (
    input logic                  clk,
    input logic                  rst,
    sin_cordic_q230_gen_if.slave bus
);
    // CORDIC gain compensation, 0.6072529350 in Q2.30
    localparam logic signed [31:0] K_GAIN = 32'sh26DD_3B6A;

    typedef enum logic [1:0] {IDLE, ROT, HOLD} state_t;

    state_t             state, state_nxt;
    logic        [31:0] phase_acc;
    logic signed [31:0] x, y, z;
    logic        [4:0]  cnt;
    logic               neg;
    logic               start, last;
    logic               fold_neg;
    logic signed [31:0] z_fold;
    logic signed [31:0] x_step, y_step, z_step;
    logic signed [31:0] y_fin;
    logic signed [31:0] sin_q;
    logic               ovr_q;
`ifdef COS_OUT_EN
    logic signed [31:0] x_fin;
    logic signed [31:0] cos_q;
`endif

    // atan(2^-k) in binary angle units (2^32 = one turn), rounded
    function automatic logic [31:0] atan_rom(input logic [4:0] k);
        case (k)
            5'd0:    atan_rom = 32'h2000_0000;
            5'd1:    atan_rom = 32'h12E4_051E;
            5'd2:    atan_rom = 32'h09FB_385B;
            5'd3:    atan_rom = 32'h0511_11D4;
            5'd4:    atan_rom = 32'h028B_0D43;
            5'd5:    atan_rom = 32'h0145_D7E1;
            5'd6:    atan_rom = 32'h00A2_F61E;
            5'd7:    atan_rom = 32'h0051_7C55;
            5'd8:    atan_rom = 32'h0028_BE53;
            5'd9:    atan_rom = 32'h0014_5F2F;
            5'd10:   atan_rom = 32'h000A_2F98;
            5'd11:   atan_rom = 32'h0005_17CC;
            5'd12:   atan_rom = 32'h0002_8BE6;
            5'd13:   atan_rom = 32'h0001_45F3;
            5'd14:   atan_rom = 32'h0000_A2FA;
            5'd15:   atan_rom = 32'h0000_517D;
            5'd16:   atan_rom = 32'h0000_28BE;
            5'd17:   atan_rom = 32'h0000_145F;
            5'd18:   atan_rom = 32'h0000_0A30;
            5'd19:   atan_rom = 32'h0000_0518;
            5'd20:   atan_rom = 32'h0000_028C;
            5'd21:   atan_rom = 32'h0000_0146;
            5'd22:   atan_rom = 32'h0000_00A3;
            5'd23:   atan_rom = 32'h0000_0051;
            5'd24:   atan_rom = 32'h0000_0029;
            5'd25:   atan_rom = 32'h0000_0014;
            5'd26:   atan_rom = 32'h0000_000A;
            5'd27:   atan_rom = 32'h0000_0005;
            5'd28:   atan_rom = 32'h0000_0003;
            5'd29:   atan_rom = 32'h0000_0001;
            default: atan_rom = 32'h0000_0000;
        endcase
    endfunction

    // State register; reset aborts any rotation in flight
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: a request is only taken in IDLE, so requests in ROT/HOLD
    // (including one coinciding with the accepting handshake) are dropped
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (bus.sample_en) begin
                start     = 1'b1;
                state_nxt = ROT;
            end
            ROT: if (cnt == 5'(ITER)) begin
                last      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Quadrant fold and one CORDIC micro-step (rotation mode, d = sign of z)
    always_comb begin
        fold_neg = phase_acc[31] ^ phase_acc[30];
        z_fold   = fold_neg ? $signed(phase_acc ^ 32'h8000_0000) : $signed(phase_acc);
        if (!z[31]) begin
            x_step = x - (y >>> cnt);
            y_step = y + (x >>> cnt);
            z_step = z - $signed(atan_rom(cnt));
        end else begin
            x_step = x + (y >>> cnt);
            y_step = y - (x >>> cnt);
            z_step = z + $signed(atan_rom(cnt));
        end
    end

    // The angle left in z after the last micro-step (up to ~2^7 LSB of sine at
    // ITER=24) is folded in to first order: sin(a+e) ~ y + x*e, cos ~ x - y*e.
    // e[rad] = z*2pi/2^32 and 2pi ~ 25736/2^12, so the term is x*z*25736 >>> 44.
    always_comb begin
        y_fin = y + 32'((80'(x) * 80'(z) * 80'sd25736) >>> 44);
`ifdef COS_OUT_EN
        x_fin = x - 32'((80'(y) * 80'(z) * 80'sd25736) >>> 44);
`endif
    end

    // Phase accumulator, rotation registers, result registers and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= INIT_PHASE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            sin_q     <= '0;
            ovr_q     <= 1'b0;
`ifdef COS_OUT_EN
            cos_q     <= '0;
`endif
        end else begin
            if (bus.sample_en && state != IDLE) ovr_q <= 1'b1;
            if (start) begin
                phase_acc <= phase_acc + bus.ftw;
                x         <= K_GAIN;
                y         <= '0;
                z         <= z_fold;
                neg       <= fold_neg;
                cnt       <= '0;
            end else if (last) begin
                sin_q <= neg ? -y_fin : y_fin;
`ifdef COS_OUT_EN
                cos_q <= neg ? -x_fin : x_fin;
`endif
            end else if (state == ROT) begin
                x   <= x_step;
                y   <= y_step;
                z   <= z_step;
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.sin_out   = sin_q;
    assign bus.overrun   = ovr_q;
`ifdef COS_OUT_EN
    assign bus.cos_out   = cos_q;
`endif
endmodule

// File: tb/tb_sin_cordic_q230_gen.sv
// Directed bench for sin_cordic_q230_gen: a vector table of exact-angle samples
// plus hand-written sequences for latency, hold/overrun, mid-rotation reset and
// a 256-point sweep against a real-valued sine model. Define COS_OUT_EN to
// also check cos_out.
module tb_sin_cordic_q230_gen;
    localparam int     ITER = 24;
    localparam longint TOL  = 64;
    localparam real    PI   = 3.14159265358979323846;

    typedef struct {
        bit                 rst_first;
        logic        [31:0] ftw;
        logic signed [31:0] sin_e;
        logic signed [31:0] cos_e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [16];

    always #5 clk = ~clk;

    sin_cordic_q230_gen_if bus ();

    sin_cordic_q230_gen #(.ITER(ITER), .INIT_PHASE(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        longint diff;
        n_checks++;
        diff = longint'(act) - longint'(exp);
        if ($isunknown(act) || diff > TOL || diff < -TOL) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h +/-%0d", name, act, exp, TOL);
        end
    endtask

    function automatic logic signed [31:0] sin_model(input logic [31:0] p);
        real a;
        a = 2.0 * PI * real'(p) / 4294967296.0;
        return 32'(longint'($sin(a) * 1073741824.0));
    endfunction

    function automatic logic signed [31:0] cos_model(input logic [31:0] p);
        real a;
        a = 2.0 * PI * real'(p) / 4294967296.0;
        return 32'(longint'($cos(a) * 1073741824.0));
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Request one sample from IDLE, wait (bounded) for out_valid, take it.
    task automatic do_sample(input logic [31:0] f, output logic signed [31:0] s,
                             output logic signed [31:0] c);
        int n;
        bus.ftw       = f;
        bus.sample_en = 1'b1;
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL sample timeout: out_valid 0 after %0d cycles, expected 1", n);
        end
        s = bus.sin_out;
`ifdef COS_OUT_EN
        c = bus.cos_out;
`else
        c = '0;
`endif
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [31:0] s, c;
        logic        [31:0] p;
        int                 n;

        // exact-angle table: ftw 90 deg, ftw 270 deg (wrap), ftw 45 deg
        vecs[0]  = '{1'b1, 32'h4000_0000, 32'sh0000_0000, 32'sh4000_0000};
        vecs[1]  = '{1'b0, 32'h4000_0000, 32'sh4000_0000, 32'sh0000_0000};
        vecs[2]  = '{1'b0, 32'h4000_0000, 32'sh0000_0000, 32'shC000_0000};
        vecs[3]  = '{1'b0, 32'h4000_0000, 32'shC000_0000, 32'sh0000_0000};
        vecs[4]  = '{1'b1, 32'hC000_0000, 32'sh0000_0000, 32'sh4000_0000};
        vecs[5]  = '{1'b0, 32'hC000_0000, 32'shC000_0000, 32'sh0000_0000};
        vecs[6]  = '{1'b0, 32'hC000_0000, 32'sh0000_0000, 32'shC000_0000};
        vecs[7]  = '{1'b0, 32'hC000_0000, 32'sh4000_0000, 32'sh0000_0000};
        vecs[8]  = '{1'b1, 32'h2000_0000, 32'sh0000_0000, 32'sh4000_0000};
        vecs[9]  = '{1'b0, 32'h2000_0000, 32'sh2D41_3CCD, 32'sh2D41_3CCD};
        vecs[10] = '{1'b0, 32'h2000_0000, 32'sh4000_0000, 32'sh0000_0000};
        vecs[11] = '{1'b0, 32'h2000_0000, 32'sh2D41_3CCD, 32'shD2BE_C333};
        vecs[12] = '{1'b0, 32'h2000_0000, 32'sh0000_0000, 32'shC000_0000};
        vecs[13] = '{1'b0, 32'h2000_0000, 32'shD2BE_C333, 32'shD2BE_C333};
        vecs[14] = '{1'b0, 32'h2000_0000, 32'shC000_0000, 32'sh0000_0000};
        vecs[15] = '{1'b0, 32'h2000_0000, 32'shD2BE_C333, 32'sh2D41_3CCD};

        rst           = 1'b1;
        bus.ftw       = '0;
        bus.sample_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset out_valid", bus.out_valid, 1'b0);
        check_bit("reset busy", bus.busy, 1'b0);
        check_bit("reset overrun", bus.overrun, 1'b0);
        check_eq("reset sin_out", bus.sin_out, 32'h0);
        rst = 1'b0;

        // latency: out_valid ITER+1 edges after the sampling edge
        bus.ftw       = 32'h0;
        bus.sample_en = 1'b1;
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
        check_bit("t1 busy in ROT", bus.busy, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq("t1 latency", 32'(n), 32'(ITER + 1));
        check_tol("t1 sin", bus.sin_out, 32'sh0);
        check_bit("t1 overrun", bus.overrun, 1'b0);
        @(posedge clk);
        #1 check_bit("t1 busy after accept", bus.busy, 1'b0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_first) do_reset();
            do_sample(vecs[i].ftw, s, c);
            check_tol($sformatf("vec%0d sin", i), s, vecs[i].sin_e);
`ifdef COS_OUT_EN
            check_tol($sformatf("vec%0d cos", i), c, vecs[i].cos_e);
`endif
        end

        // hold with out_ready low, extra request while busy and at the handshake
        do_reset();
        do_sample(32'h4000_0000, s, c);
        check_tol("t3 first sin", s, 32'sh0);
        bus.out_ready = 1'b0;
        bus.sample_en = 1'b1;
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check_bit("t3 out_valid", bus.out_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) bus.sample_en = 1'b1;
            @(posedge clk);
            #1 bus.sample_en = 1'b0;
            check_bit("t3 out_valid held", bus.out_valid, 1'b1);
            check_tol("t3 sin held", bus.sin_out, 32'sh4000_0000);
        end
        check_bit("t3 overrun", bus.overrun, 1'b1);
        check_bit("t3 busy in HOLD", bus.busy, 1'b1);
        bus.out_ready = 1'b1;
        bus.sample_en = 1'b1;
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
        check_bit("t3 accept out_valid", bus.out_valid, 1'b0);
        check_bit("t3 handshake request dropped", bus.busy, 1'b0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t3 next sin 180", s, 32'sh0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t3 next sin 270", s, 32'shC000_0000);
        check_bit("t3 overrun sticky", bus.overrun, 1'b1);

        // reset at ROT step 10
        do_reset();
        check_bit("t4 overrun cleared", bus.overrun, 1'b0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t4 sin 0", s, 32'sh0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t4 sin 90", s, 32'sh4000_0000);
        bus.sample_en = 1'b1;
        @(posedge clk);
        #1 bus.sample_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_bit("t4 rst out_valid", bus.out_valid, 1'b0);
        check_bit("t4 rst busy", bus.busy, 1'b0);
        check_eq("t4 rst sin_out", bus.sin_out, 32'h0);
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.out_valid) n++;
        end
        check_eq("t4 no output pulse", 32'(n), 32'h0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t4 after rst sin 0", s, 32'sh0);
        do_sample(32'h4000_0000, s, c);
        check_tol("t4 after rst sin 90", s, 32'sh4000_0000);

        // 256-point sweep against the real model
        do_reset();
        p = 32'h0;
        for (int i = 0; i < 256; i++) begin
            do_sample(32'h0100_0000, s, c);
            check_tol($sformatf("t5 sin p=%08h", p), s, sin_model(p));
`ifdef COS_OUT_EN
            check_tol($sformatf("t5 cos p=%08h", p), c, cos_model(p));
`endif
            p = p + 32'h0100_0000;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
